// File: rtl/l1b_cycle_ctrl.sv
// L1B bus cycle sequencer: derives cpu_phi2 from hsclk and steers each
// CPU cycle to local SRAM, the BBC host bus (phi0 aligned) or nowhere.
module l1b_cycle_ctrl #(
  parameter int unsigned HS_DIV = 4
) (
  input  logic        hsclk,
  input  logic        resetb,
  input  logic        bbc_phi0,
  input  logic        host_rdy,
  input  logic        cpu_vda,
  input  logic        cpu_vpa,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_bank,
  input  logic [15:0] cpu_addr,
  input  logic        map_bbc_all,
  output logic        cpu_phi2,
  output logic        ram_ceb,
  output logic        ram_oeb,
  output logic        ram_web,
  output logic        bbc_addr_en,
  output logic        bbc_data_oe,
  output logic        lat_en,
  output logic        bbc_sync,
  output logic        host_active
);

  typedef enum logic [2:0] {
    FAST_LO,
    FAST_HI,
    HOST_WAIT,
    HOST_LO,
    HOST_HI
  } state_e;

  typedef enum logic [1:0] {
    K_INT,
    K_LOCAL,
    K_HOST
  } kind_e;

  localparam logic [3:0] LAST    = 4'(HS_DIV - 1);
  localparam logic [3:0] WE_LAST = 4'(HS_DIV - 2);

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d, kind_now;
  logic [3:0] cnt_q, cnt_d;
  logic       rnw_q, rnw_d;
  logic [2:0] s_q;
  logic       rise, fall;

  logic phi2_q, ceb_q, oeb_q, web_q;
  logic aen_q, doe_q, lat_q, sync_q, act_q;
  logic phi2_d, ceb_d, oeb_d, web_d;
  logic aen_d, doe_d, lat_d, sync_d, act_d;
  logic fast_local, hold, in_host;

  logic unused_addr;
  assign unused_addr = ^cpu_addr[7:0];

  assign rise = s_q[1] & ~s_q[2];
  assign fall = ~s_q[1] & s_q[2];

  always_comb begin
    kind_now = K_LOCAL;
    if (!(cpu_vda | cpu_vpa)) begin
      kind_now = K_INT;
    end else if (cpu_bank == 8'hFF ||
                 (cpu_bank == 8'h00 &&
                  (map_bbc_all ||
                   cpu_addr[15:8] inside {8'hFC, 8'hFD, 8'hFE}))) begin
      kind_now = K_HOST;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    rnw_d   = rnw_q;
    sync_d  = 1'b0;
    case (state_q)
      FAST_LO: begin
        if (cnt_q == LAST) begin
          kind_d  = kind_now;
          rnw_d   = cpu_rnw;
          cnt_d   = 4'd0;
          state_d = (kind_now == K_HOST) ? HOST_WAIT : FAST_HI;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FAST_HI: begin
        if (cnt_q == LAST) begin
          cnt_d   = 4'd0;
          state_d = FAST_LO;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOST_WAIT: begin
        if (fall) begin
          state_d = HOST_LO;
          sync_d  = cpu_vpa & cpu_vda;
        end
      end
      HOST_LO: begin
        sync_d = sync_q;
        if (rise) state_d = HOST_HI;
      end
      HOST_HI: begin
        sync_d = sync_q;
        if (fall) begin
          // Not-ready stretches with phi2 held high; SYNC only on first pass.
          sync_d = 1'b0;
          if (host_rdy) begin
            state_d = FAST_LO;
            cnt_d   = 4'd0;
          end
        end
      end
      default: begin
        state_d = FAST_LO;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    fast_local = (state_d == FAST_HI) && (kind_d == K_LOCAL);
    hold       = (state_q == HOST_HI) && (state_d == FAST_LO);
    in_host    = (state_d == HOST_LO) || (state_d == HOST_HI);
    phi2_d     = (state_d == FAST_HI) || (state_d == HOST_HI);
    ceb_d      = ~fast_local;
    oeb_d      = ~(fast_local && rnw_d);
    web_d      = ~(fast_local && !rnw_d && (cnt_d <= WE_LAST));
    aen_d      = in_host || hold;
    doe_d      = !rnw_d && ((state_d == HOST_HI) || hold);
    lat_d      = rnw_d && (state_d == HOST_HI);
    act_d      = in_host || (state_d == HOST_WAIT);
  end

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      state_q <= FAST_LO;
      cnt_q   <= 4'd0;
      kind_q  <= K_INT;
      rnw_q   <= 1'b1;
      s_q     <= 3'b000;
      phi2_q  <= 1'b0;
      ceb_q   <= 1'b1;
      oeb_q   <= 1'b1;
      web_q   <= 1'b1;
      aen_q   <= 1'b0;
      doe_q   <= 1'b0;
      lat_q   <= 1'b0;
      sync_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      rnw_q   <= rnw_d;
      s_q     <= {s_q[1:0], bbc_phi0};
      phi2_q  <= phi2_d;
      ceb_q   <= ceb_d;
      oeb_q   <= oeb_d;
      web_q   <= web_d;
      aen_q   <= aen_d;
      doe_q   <= doe_d;
      lat_q   <= lat_d;
      sync_q  <= sync_d;
      act_q   <= act_d;
    end
  end

  assign cpu_phi2    = phi2_q;
  assign ram_ceb     = ceb_q;
  assign ram_oeb     = oeb_q;
  assign ram_web     = web_q;
  assign bbc_addr_en = aen_q;
  assign bbc_data_oe = doe_q;
  assign lat_en      = lat_q;
  assign bbc_sync    = sync_q;
  assign host_active = act_q;

endmodule

// File: tb/tb_l1b_cycle_ctrl.sv
// Directed bench for l1b_cycle_ctrl: fast local cycles, phi0-aligned
// host cycles, RDY stretching, SYNC and asynchronous reset.
module tb_l1b_cycle_ctrl;

  logic        hsclk = 1'b0;
  logic        resetb = 1'b1;
  logic        bbc_phi0 = 1'b1;
  logic        host_rdy = 1'b1;
  logic        cpu_vda = 1'b0;
  logic        cpu_vpa = 1'b0;
  logic        cpu_rnw = 1'b1;
  logic [7:0]  cpu_bank = 8'h00;
  logic [15:0] cpu_addr = 16'h0000;
  logic        map_bbc_all = 1'b0;
  logic cpu_phi2, ram_ceb, ram_oeb, ram_web;
  logic bbc_addr_en, bbc_data_oe, lat_en, bbc_sync, host_active;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_fall = 0;
  int last_rise = 0;
  int n_falls = 0;

  logic phi2_a [0:63];
  logic ceb_a  [0:63];
  logic oeb_a  [0:63];
  logic web_a  [0:63];
  logic aen_a  [0:63];

  l1b_cycle_ctrl #(.HS_DIV(4)) dut (
    .hsclk       (hsclk),
    .resetb      (resetb),
    .bbc_phi0    (bbc_phi0),
    .host_rdy    (host_rdy),
    .cpu_vda     (cpu_vda),
    .cpu_vpa     (cpu_vpa),
    .cpu_rnw     (cpu_rnw),
    .cpu_bank    (cpu_bank),
    .cpu_addr    (cpu_addr),
    .map_bbc_all (map_bbc_all),
    .cpu_phi2    (cpu_phi2),
    .ram_ceb     (ram_ceb),
    .ram_oeb     (ram_oeb),
    .ram_web     (ram_web),
    .bbc_addr_en (bbc_addr_en),
    .bbc_data_oe (bbc_data_oe),
    .lat_en      (lat_en),
    .bbc_sync    (bbc_sync),
    .host_active (host_active)
  );

  always #5 hsclk = ~hsclk;

  always @(posedge hsclk) cyc <= cyc + 1;

  // phi0 = hsclk/16, edges 1 time unit after an hsclk rise
  initial begin : phi0_gen
    forever begin
      repeat (8) @(posedge hsclk);
      #1 bbc_phi0 = ~bbc_phi0;
      if (!bbc_phi0) begin
        last_fall = cyc;
        n_falls++;
      end else begin
        last_rise = cyc;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  function automatic logic [8:0] outs();
    return {cpu_phi2, ram_ceb, ram_oeb, ram_web, bbc_addr_en,
            bbc_data_oe, lat_en, bbc_sync, host_active};
  endfunction

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge hsclk);
      phi2_a[i] = cpu_phi2;
      ceb_a[i]  = ram_ceb;
      oeb_a[i]  = ram_oeb;
      web_a[i]  = ram_web;
      aen_a[i]  = bbc_addr_en;
    end
  endtask

  task automatic test_reset();
    #2 resetb = 1'b0;
    @(negedge hsclk);
    tests++;
    if (outs() !== 9'b0_111_00000) begin
      fails++;
      $display("FAIL reset_outputs got=%b exp=%b", outs(), 9'b0_111_00000);
    end
    repeat (3) @(negedge hsclk);
    tests++;
    if (outs() !== 9'b0_111_00000) begin
      fails++;
      $display("FAIL reset_held got=%b exp=%b", outs(), 9'b0_111_00000);
    end
  endtask

  task automatic test_local_read();
    int r1, r2, rs, hi, cl, ol, bad, bad2;
    cpu_vda = 1'b1; cpu_vpa = 1'b0; cpu_rnw = 1'b1;
    cpu_bank = 8'h01; cpu_addr = 16'h0100;
    @(negedge hsclk);
    resetb = 1'b1;
    repeat (8) @(negedge hsclk);
    capture(40);
    r1 = -1; r2 = -1;
    for (int i = 1; i < 40; i++) begin
      if (phi2_a[i] && !phi2_a[i-1]) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
    end
    tests++;
    if (r1 < 0 || r2 < 0 || (r2 - r1) != 8) begin
      fails++;
      $display("FAIL lr_phi2_period got=%0d exp=8", r2 - r1);
    end
    rs = (r1 < 1) ? 1 : r1;
    hi = 0; cl = 0; ol = 0;
    for (int i = rs; i < 40 && phi2_a[i]; i++) hi++;
    for (int i = rs; i < 40 && !ceb_a[i]; i++) cl++;
    for (int i = rs; i < 40 && !oeb_a[i]; i++) ol++;
    tests++;
    if (hi != 4) begin
      fails++;
      $display("FAIL lr_phi2_high got=%0d exp=4", hi);
    end
    tests++;
    if (cl != 4 || ol != 4) begin
      fails++;
      $display("FAIL lr_ceb_oeb_low got=%0d/%0d exp=4/4", cl, ol);
    end
    bad = 0; bad2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (ceb_a[i] !== ~phi2_a[i]) bad++;
      if (web_a[i] !== 1'b1 || aen_a[i] !== 1'b0) bad2++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL lr_ceb_align got=%0d bad samples exp=0", bad);
    end
    tests++;
    if (bad2 != 0) begin
      fails++;
      $display("FAIL lr_web_aen_idle got=%0d bad samples exp=0", bad2);
    end
  endtask

  task automatic test_local_write();
    int r;
    cpu_vda = 1'b1; cpu_rnw = 1'b0;
    cpu_bank = 8'h00; cpu_addr = 16'h1234; map_bbc_all = 1'b0;
    repeat (8) @(negedge hsclk);
    capture(32);
    r = -1;
    for (int i = 1; i < 21; i++)
      if (r < 0 && phi2_a[i] && !phi2_a[i-1]) r = i;
    if (r < 0) r = 1;
    tests++;
    if ({web_a[r], web_a[r+1], web_a[r+2], web_a[r+3]} !== 4'b0001) begin
      fails++;
      $display("FAIL lw_web_pulse got=%b exp=0001",
               {web_a[r], web_a[r+1], web_a[r+2], web_a[r+3]});
    end
    tests++;
    if ({phi2_a[r+3], phi2_a[r+4]} !== 2'b10) begin
      fails++;
      $display("FAIL lw_phi2_fall got=%b exp=10", {phi2_a[r+3], phi2_a[r+4]});
    end
    tests++;
    if ({ceb_a[r], oeb_a[r]} !== 2'b01) begin
      fails++;
      $display("FAIL lw_ceb_oeb got=%b exp=01", {ceb_a[r], oeb_a[r]});
    end
  endtask

  task automatic test_host_read();
    int k, bad, d;
    cpu_vda = 1'b1; cpu_vpa = 1'b0; cpu_rnw = 1'b1;
    cpu_bank = 8'h00; cpu_addr = 16'hFE40; host_rdy = 1'b1;
    k = 0;
    while (!host_active && k < 40) begin @(negedge hsclk); k++; end
    tests++;
    if (host_active !== 1'b1) begin
      fails++;
      $display("FAIL hr_start got=%b exp=1", host_active);
    end
    bad = 0; k = 0;
    while (!bbc_addr_en && k < 40) begin
      if (cpu_phi2) bad++;
      @(negedge hsclk); k++;
    end
    tests++;
    if (bad != 0 || cpu_phi2 !== 1'b0) begin
      fails++;
      $display("FAIL hr_phi2_low_wait got=%0d high samples exp=0", bad);
    end
    d = cyc - last_fall;
    tests++;
    if (bbc_addr_en !== 1'b1 || d < 2 || d > 3) begin
      fails++;
      $display("FAIL hr_aen_after_fall got=%0d hsclk exp=2..3", d);
    end
    k = 0;
    while (!cpu_phi2 && k < 40) begin @(negedge hsclk); k++; end
    d = cyc - last_rise;
    tests++;
    if (cpu_phi2 !== 1'b1 || d < 2 || d > 3) begin
      fails++;
      $display("FAIL hr_phi2_after_rise got=%0d hsclk exp=2..3", d);
    end
    tests++;
    if ({lat_en, bbc_data_oe, bbc_addr_en} !== 3'b101) begin
      fails++;
      $display("FAIL hr_hi_strobes got=%b exp=101",
               {lat_en, bbc_data_oe, bbc_addr_en});
    end
    k = 0;
    while (host_active && k < 40) begin @(negedge hsclk); k++; end
    d = cyc - last_fall;
    tests++;
    if (host_active !== 1'b0 || d < 2 || d > 3) begin
      fails++;
      $display("FAIL hr_exit_after_fall got=%0d hsclk exp=2..3", d);
    end
    tests++;
    if ({cpu_phi2, bbc_addr_en, lat_en} !== 3'b010) begin
      fails++;
      $display("FAIL hr_exit_hold got=%b exp=010",
               {cpu_phi2, bbc_addr_en, lat_en});
    end
    cpu_vda = 1'b0;
    @(negedge hsclk);
    tests++;
    if (bbc_addr_en !== 1'b0) begin
      fails++;
      $display("FAIL hr_hold_one got=%b exp=0", bbc_addr_en);
    end
  endtask

  task automatic test_host_write_stretch();
    int k, bad, f0, d;
    host_rdy = 1'b0;
    cpu_vda = 1'b1; cpu_vpa = 1'b0; cpu_rnw = 1'b0;
    cpu_bank = 8'hFF; cpu_addr = 16'h8000;
    k = 0;
    while (!host_active && k < 60) begin @(negedge hsclk); k++; end
    k = 0;
    while (!cpu_phi2 && k < 60) begin @(negedge hsclk); k++; end
    f0 = n_falls;
    tests++;
    if ({cpu_phi2, bbc_data_oe, lat_en} !== 3'b110) begin
      fails++;
      $display("FAIL hw_hi_strobes got=%b exp=110",
               {cpu_phi2, bbc_data_oe, lat_en});
    end
    bad = 0; k = 0;
    while (host_active && k < 120) begin
      if (!(cpu_phi2 && bbc_data_oe && bbc_addr_en) || lat_en) bad++;
      if (n_falls == f0 + 2 && cyc >= last_fall + 4) host_rdy = 1'b1;
      @(negedge hsclk); k++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hw_stretch_high got=%0d bad samples exp=0", bad);
    end
    d = cyc - last_fall;
    tests++;
    if (host_active !== 1'b0 || (n_falls - f0) != 3 || d < 2 || d > 3) begin
      fails++;
      $display("FAIL hw_exit_third_fall got=%0d falls/%0d hsclk exp=3/2..3",
               n_falls - f0, d);
    end
    tests++;
    if ({cpu_phi2, bbc_data_oe, bbc_addr_en} !== 3'b011) begin
      fails++;
      $display("FAIL hw_exit_hold got=%b exp=011",
               {cpu_phi2, bbc_data_oe, bbc_addr_en});
    end
    cpu_vda = 1'b0; cpu_rnw = 1'b1;
    @(negedge hsclk);
    tests++;
    if (bbc_data_oe !== 1'b0) begin
      fails++;
      $display("FAIL hw_doe_release got=%b exp=0", bbc_data_oe);
    end
  endtask

  task automatic test_sync();
    int k, bad, seen;
    cpu_vda = 1'b1; cpu_vpa = 1'b1; cpu_rnw = 1'b1;
    cpu_bank = 8'h00; cpu_addr = 16'hFC00; host_rdy = 1'b1;
    k = 0;
    while (!host_active && k < 60) begin @(negedge hsclk); k++; end
    bad = 0; seen = 0; k = 0;
    while (host_active && k < 60) begin
      if (bbc_sync !== (bbc_addr_en & host_active)) bad++;
      if (bbc_sync) seen++;
      @(negedge hsclk); k++;
    end
    cpu_vda = 1'b0; cpu_vpa = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bbc_sync !== 1'b0) bad++;
      @(negedge hsclk);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sync_window got=%0d bad samples exp=0", bad);
    end
    tests++;
    if (seen == 0) begin
      fails++;
      $display("FAIL sync_seen got=%0d exp=nonzero", seen);
    end
  endtask

  task automatic test_reset_mid_host();
    int k;
    logic [3:0] v;
    logic [4:0] v2;
    logic       hv;
    cpu_vda = 1'b1; cpu_vpa = 1'b0; cpu_rnw = 1'b1;
    cpu_bank = 8'h00; cpu_addr = 16'hFD00; host_rdy = 1'b1;
    k = 0;
    while (!host_active && k < 60) begin @(negedge hsclk); k++; end
    k = 0;
    while (!cpu_phi2 && k < 40) begin @(negedge hsclk); k++; end
    #2 resetb = 1'b0;
    #1;
    tests++;
    if (outs() !== 9'b0_111_00000) begin
      fails++;
      $display("FAIL rst_async got=%b exp=%b", outs(), 9'b0_111_00000);
    end
    cpu_bank = 8'h01; cpu_addr = 16'h2000;
    @(negedge hsclk);
    @(negedge hsclk);
    resetb = 1'b1;
    v = '0; hv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge hsclk);
      v = {v[2:0], cpu_phi2};
      hv = hv | host_active | bbc_addr_en;
    end
    tests++;
    if (v !== 4'b0001) begin
      fails++;
      $display("FAIL rst_first_fast got=%b exp=0001", v);
    end
    v2 = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge hsclk);
      v2 = {v2[3:0], cpu_phi2};
      hv = hv | host_active | bbc_addr_en;
    end
    tests++;
    if (v2 !== 5'b11100) begin
      fails++;
      $display("FAIL rst_fast_shape got=%b exp=11100", v2);
    end
    tests++;
    if (hv !== 1'b0) begin
      fails++;
      $display("FAIL rst_spurious_rise got=%b exp=0", hv);
    end
  endtask

  initial begin
    test_reset();
    test_local_read();
    test_local_write();
    test_host_read();
    test_host_write_stretch();
    test_sync();
    test_reset_mid_host();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
